// File: rtl/dm_line_adapter.sv
// Word-level load/store front end for a 256-bit line data memory.
// One write-back line buffer with a dirty bit; same-line accesses and store combining are handled locally.
module dm_line_adapter #(
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 16,
  parameter int LADDR_W    = 12,
  localparam int IDX_W     = $clog2(LINE_WORDS),
  localparam int ADDR_W    = LADDR_W + IDX_W,
  localparam int LINE_W    = WORD_W * LINE_WORDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [WORD_W-1:0]  req_wdata,
  output logic               resp_valid,
  output logic [WORD_W-1:0]  resp_rdata,
  input  logic               flush_req,
  output logic               flush_done,
  output logic [LADDR_W-1:0] dm_raddr,
  input  logic [LINE_W-1:0]  dm_rdata,
  output logic               dm_wen,
  output logic [LADDR_W-1:0] dm_waddr,
  output logic [LINE_W-1:0]  dm_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_FILL, S_RESP} state_t;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  state_t              state_q, state_d;
  logic                line_valid_q, line_valid_d;
  logic                dirty_q, dirty_d;
  logic [LADDR_W-1:0]  tag_q, tag_d;
  logic [LADDR_W-1:0]  raddr_q, raddr_d;
  line_t               buf_q, buf_d;
  logic                pend_we_q, pend_we_d;
  logic                pend_flush_q, pend_flush_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [WORD_W-1:0]   pend_wdata_q, pend_wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                flush_done_q, flush_done_d;

  logic                accept, hit;
  logic [LADDR_W-1:0]  req_line, pend_line;
  logic [IDX_W-1:0]    req_idx, pend_idx;
  line_t               fill_line;

  assign req_line  = req_addr[ADDR_W-1:IDX_W];
  assign req_idx   = req_addr[IDX_W-1:0];
  assign pend_line = pend_addr_q[ADDR_W-1:IDX_W];
  assign pend_idx  = pend_addr_q[IDX_W-1:0];

  assign req_ready = rst & (state_q == S_IDLE) & ~flush_req;
  assign accept    = req_valid & req_ready;
  assign hit       = line_valid_q & (tag_q == req_line);

  // The read port places word 0 in the MSBs; the buffer keeps word 0 at index 0.
  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      fill_line[i] = dm_rdata[LINE_W-1-WORD_W*i -: WORD_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    raddr_d      = raddr_q;
    buf_d        = buf_q;
    pend_we_d    = pend_we_q;
    pend_flush_d = pend_flush_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    rdata_d      = '0;
    flush_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_req) begin
          if (dirty_q) begin
            pend_flush_d = 1'b1;
            state_d      = S_FLUSH;
          end else begin
            flush_done_d = 1'b1;
          end
        end else if (accept) begin
          pend_we_d    = req_we;
          pend_addr_d  = req_addr;
          pend_wdata_d = req_wdata;
          pend_flush_d = 1'b0;
          if (hit) begin
            if (req_we) begin
              buf_d[req_idx] = req_wdata;
              dirty_d        = 1'b1;
            end else begin
              rdata_d = buf_q[req_idx];
            end
            state_d = S_RESP;
          end else if (dirty_q) begin
            state_d = S_FLUSH;
          end else begin
            raddr_d = req_line;
            state_d = S_FILL;
          end
        end
      end
      S_FLUSH: begin
        dirty_d = 1'b0;
        if (pend_flush_q) begin
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          raddr_d = pend_line;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        buf_d        = fill_line;
        tag_d        = pend_line;
        line_valid_d = 1'b1;
        if (pend_we_q) begin
          buf_d[pend_idx] = pend_wdata_q;
          dirty_d         = 1'b1;
        end else begin
          rdata_d = fill_line[pend_idx];
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      line_valid_q <= 1'b0;
      dirty_q      <= 1'b0;
      tag_q        <= '0;
      raddr_q      <= '0;
      buf_q        <= '0;
      pend_we_q    <= 1'b0;
      pend_flush_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      rdata_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      raddr_q      <= raddr_d;
      buf_q        <= buf_d;
      pend_we_q    <= pend_we_d;
      pend_flush_q <= pend_flush_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      rdata_q      <= rdata_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Outputs are gated by rst so an operation caught by reset never reaches the memory.
  assign resp_valid = rst & (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign flush_done = rst & flush_done_q;
  assign dm_wen     = rst & (state_q == S_FLUSH);
  assign dm_waddr   = dm_wen ? tag_q : '0;
  assign dm_wdata   = dm_wen ? buf_q : '0;
  assign dm_raddr   = raddr_q;

endmodule

// File: tb/tb_dm_line_adapter.sv
// Bench for dm_line_adapter: behavioural line memory, word-level reference store and response scoreboard.
module tb_dm_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [15:0]  req_addr, req_wdata;
  logic         resp_valid;
  logic [15:0]  resp_rdata;
  logic         flush_req, flush_done;
  logic [11:0]  dm_raddr, dm_waddr;
  logic [255:0] dm_rdata, dm_wdata;
  logic         dm_wen;

  logic         pre_we = 1'b0;
  logic [11:0]  pre_line = '0;
  logic [255:0] pre_data = '0;

  logic [255:0] mem [4096];
  logic [15:0]  ref_mem [logic [15:0]];
  logic [15:0]  exp_q [$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dm_line_adapter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .flush_req(flush_req), .flush_done(flush_done),
    .dm_raddr(dm_raddr), .dm_rdata(dm_rdata),
    .dm_wen(dm_wen), .dm_waddr(dm_waddr), .dm_wdata(dm_wdata)
  );

  // Memory stores lines in write-port lane order; the read port returns word 0 in the MSBs.
  always @(posedge clk) begin
    if (pre_we) mem[pre_line] <= pre_data;
    else if (dm_wen) mem[dm_waddr] <= dm_wdata;
  end

  always_comb begin
    dm_rdata = '0;
    for (int i = 0; i < 16; i++) dm_rdata[255-16*i -: 16] = mem[dm_raddr][16*i +: 16];
  end

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 16'h0000;
  endfunction

  task automatic set_line(input logic [11:0] line, input logic [15:0] base);
    for (int i = 0; i < 16; i++) ref_mem[{line, 4'(i)}] = base + 16'(i);
  endtask

  task automatic commit_line(input logic [11:0] line);
    logic [255:0] lv;
    for (int i = 0; i < 16; i++) lv[16*i +: 16] = ref_rd({line, 4'(i)});
    @(negedge clk);
    pre_we = 1'b1; pre_line = line; pre_data = lv;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Drives one request and records what the DUT did until the response; lat=0 means no response.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       output int lat, output logic [15:0] rd, output int wen_cnt,
                       output logic [11:0] waddr, output logic [255:0] wline);
    int w;
    lat = 0; rd = '0; wen_cnt = 0; waddr = '0; wline = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (dm_wen) begin
        wen_cnt++;
        waddr = dm_waddr;
        wline = dm_wdata;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0123; req_wdata = '0;
    flush_req = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp: got %b want 0", resp_valid); end
    tests++; if (dm_wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b want 0", dm_wen); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    rst = 1'b1; req_valid = 1'b0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    tests++; if (dm_raddr !== 12'h000) begin fails++; $display("FAIL reset_raddr: got %h want 000", dm_raddr); end
  endtask

  task automatic test_clean_miss();
    int lat, wc; logic [15:0] rd, e; logic [11:0] wa; logic [255:0] wl;
    set_line(12'h012, 16'h1200);
    ref_mem[16'h0123] = 16'hBEEF;
    commit_line(12'h012);
    set_line(12'h045, 16'h4500);
    commit_line(12'h045);
    exp_q.push_back(ref_rd(16'h0123));
    issue(1'b0, 16'h0123, 16'h0000, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 2) begin fails++; $display("FAIL miss_latency: got %0d want 2", lat); end
    tests++; if (rd !== e) begin fails++; $display("FAIL miss_rdata: got %h want %h", rd, e); end
    tests++; if (dm_raddr !== 12'h012) begin fails++; $display("FAIL miss_raddr: got %h want 012", dm_raddr); end
    tests++; if (wc !== 0) begin fails++; $display("FAIL miss_no_write: got %0d want 0", wc); end
    exp_q.push_back(ref_rd(16'h0125));
    issue(1'b0, 16'h0125, 16'h0000, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 1) begin fails++; $display("FAIL hit_latency: got %0d want 1", lat); end
    tests++; if (rd !== e) begin fails++; $display("FAIL hit_rdata: got %h want %h", rd, e); end
    tests++; if (wc !== 0) begin fails++; $display("FAIL hit_no_write: got %0d want 0", wc); end
  endtask

  task automatic test_store_combine();
    int lat, wc; logic [15:0] rd, e; logic [11:0] wa; logic [255:0] wl, el;
    logic [15:0] st_addr [2];
    logic [15:0] st_data [2];
    st_addr[0] = 16'h0120; st_data[0] = 16'h1111;
    st_addr[1] = 16'h012F; st_data[1] = 16'h2222;
    for (int k = 0; k < 2; k++) begin
      ref_mem[st_addr[k]] = st_data[k];
      exp_q.push_back(16'h0000);
      issue(1'b1, st_addr[k], st_data[k], lat, rd, wc, wa, wl);
      e = exp_q.pop_front();
      tests++; if (lat !== 1) begin fails++; $display("FAIL store%0d_latency: got %0d want 1", k, lat); end
      tests++; if (rd !== e) begin fails++; $display("FAIL store%0d_rdata: got %h want %h", k, rd, e); end
      tests++; if (wc !== 0) begin fails++; $display("FAIL store%0d_no_write: got %0d want 0", k, wc); end
    end
    for (int i = 0; i < 16; i++) el[16*i +: 16] = ref_rd({12'h012, 4'(i)});
    exp_q.push_back(ref_rd(16'h0450));
    issue(1'b0, 16'h0450, 16'h0000, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 3) begin fails++; $display("FAIL dirty_latency: got %0d want 3", lat); end
    tests++; if (wc !== 1) begin fails++; $display("FAIL dirty_wen_cycles: got %0d want 1", wc); end
    tests++; if (wa !== 12'h012) begin fails++; $display("FAIL dirty_waddr: got %h want 012", wa); end
    tests++; if (wl[15:0] !== 16'h1111) begin fails++; $display("FAIL dirty_word0_lsb: got %h want 1111", wl[15:0]); end
    tests++; if (wl[255:240] !== 16'h2222) begin fails++; $display("FAIL dirty_word15_msb: got %h want 2222", wl[255:240]); end
    tests++; if (wl !== el) begin fails++; $display("FAIL dirty_line: got %h want %h", wl, el); end
    tests++; if (rd !== e) begin fails++; $display("FAIL dirty_rdata: got %h want %h", rd, e); end
    tests++; if (dm_raddr !== 12'h045) begin fails++; $display("FAIL dirty_raddr: got %h want 045", dm_raddr); end
  endtask

  task automatic test_round_trip();
    int lat, wc; logic [15:0] rd, e; logic [11:0] wa; logic [255:0] wl;
    logic [15:0] addrs [3];
    int          lats [3];
    addrs[0] = 16'h0120; lats[0] = 2;
    addrs[1] = 16'h012F; lats[1] = 1;
    addrs[2] = 16'h0123; lats[2] = 1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ref_rd(addrs[k]));
      issue(1'b0, addrs[k], 16'h0000, lat, rd, wc, wa, wl);
      e = exp_q.pop_front();
      tests++; if (lat !== lats[k]) begin fails++; $display("FAIL trip%0d_latency: got %0d want %0d", k, lat, lats[k]); end
      tests++; if (rd !== e) begin fails++; $display("FAIL trip%0d_rdata: got %h want %h", k, rd, e); end
      tests++; if (wc !== 0) begin fails++; $display("FAIL trip%0d_no_write: got %0d want 0", k, wc); end
    end
  endtask

  task automatic test_flush();
    int lat, wc; logic [15:0] rd, e; logic [11:0] wa; logic [255:0] wl;
    ref_mem[16'h0124] = 16'h3333;
    exp_q.push_back(16'h0000);
    issue(1'b1, 16'h0124, 16'h3333, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 1 || rd !== e) begin fails++; $display("FAIL flush_prep_store: got lat %0d rd %h want lat 1 rd %h", lat, rd, e); end
    @(negedge clk);
    flush_req = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0777;
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    @(negedge clk);
    tests++; if (dm_wen !== 1'b1) begin fails++; $display("FAIL flush_wen: got %b want 1", dm_wen); end
    tests++; if (dm_waddr !== 12'h012) begin fails++; $display("FAIL flush_waddr: got %h want 012", dm_waddr); end
    tests++; if (dm_wdata[16*4 +: 16] !== 16'h3333) begin fails++; $display("FAIL flush_word4: got %h want 3333", dm_wdata[16*4 +: 16]); end
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL flush_done_early: got %b want 0", flush_done); end
    @(negedge clk);
    tests++; if (flush_done !== 1'b1 || dm_wen !== 1'b0) begin fails++; $display("FAIL flush_done1: got done %b wen %b want 1 0", flush_done, dm_wen); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL flush_no_resp: got %b want 0", resp_valid); end
    @(negedge clk);
    tests++; if (flush_done !== 1'b1 || dm_wen !== 1'b0) begin fails++; $display("FAIL flush_done2: got done %b wen %b want 1 0", flush_done, dm_wen); end
    flush_req = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    tests++; if (flush_done !== 1'b0) begin fails++; $display("FAIL flush_done_pulse: got %b want 0", flush_done); end
    tests++; if (mem[12'h012][16*4 +: 16] !== 16'h3333) begin fails++; $display("FAIL flush_mem_word4: got %h want 3333", mem[12'h012][16*4 +: 16]); end
    exp_q.push_back(ref_rd(16'h0124));
    issue(1'b0, 16'h0124, 16'h0000, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 1) begin fails++; $display("FAIL flush_keeps_valid_latency: got %0d want 1", lat); end
    tests++; if (rd !== e) begin fails++; $display("FAIL flush_keeps_valid_rdata: got %h want %h", rd, e); end
  endtask

  task automatic test_reset_mid();
    int lat, wc, bad; logic [15:0] rd, e, old; logic [11:0] wa; logic [255:0] wl;
    old = ref_rd(16'h0126);
    ref_mem[16'h0126] = 16'h4444;
    exp_q.push_back(16'h0000);
    issue(1'b1, 16'h0126, 16'h4444, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 1 || rd !== e) begin fails++; $display("FAIL abort_prep_store: got lat %0d rd %h want lat 1 rd %h", lat, rd, e); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0777;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_accept_ready: got %b want 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (dm_wen !== 1'b1) begin fails++; $display("FAIL abort_in_flush: got %b want 1", dm_wen); end
    rst = 1'b0;
    #1;
    tests++; if (dm_wen !== 1'b0) begin fails++; $display("FAIL abort_wen_gated: got %b want 0", dm_wen); end
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (dm_wen !== 1'b0 || resp_valid !== 1'b0) bad++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (dm_wen !== 1'b0 || resp_valid !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    tests++; if (mem[12'h012][16*6 +: 16] !== old) begin fails++; $display("FAIL abort_mem_untouched: got %h want %h", mem[12'h012][16*6 +: 16], old); end
    ref_mem[16'h0126] = old;
    exp_q.push_back(ref_rd(16'h0126));
    issue(1'b0, 16'h0126, 16'h0000, lat, rd, wc, wa, wl);
    e = exp_q.pop_front();
    tests++; if (lat !== 2) begin fails++; $display("FAIL abort_reload_latency: got %0d want 2", lat); end
    tests++; if (rd !== e) begin fails++; $display("FAIL abort_reload_rdata: got %h want %h", rd, e); end
    tests++; if (wc !== 0) begin fails++; $display("FAIL abort_reload_no_write: got %0d want 0", wc); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_store_combine();
    test_round_trip();
    test_flush();
    test_reset_mid();
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_line_adapter.md
Name: dm_line_adapter

Overview:
- Word-level load/store front end sitting directly upstream of the data memory.
- Converts 16-bit word requests from the execute/MEM stage into 256-bit line reads and writes on the data memory's read/write ports.
- Holds one write-back line buffer (16 words) with a dirty bit.
- Repeated accesses to the same line are serviced locally, and stores are combined before write-back.

Parameters:
- WORD_W, 16, data word width in bits.
- LINE_WORDS, 16, words per line; word index width is 4.
- LADDR_W, 12, line address width; full word address is LADDR_W+4 = 16 bits.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- req_valid, input, 1, CPU request present.
- req_ready, output, 1, adapter can accept a request this cycle.
- req_we, input, 1, 1 = store, 0 = load.
- req_addr, input, 16, word address; [15:4] is the line address, [3:0] is the word index.
- req_wdata, input, 16, store data.
- resp_valid, output, 1, one-cycle pulse: request complete.
- resp_rdata, output, 16, load data; valid when resp_valid=1 and the request was a load, 0 otherwise.
- flush_req, input, 1, request write-back of the dirty line.
- flush_done, output, 1, one-cycle pulse when the flush completes.
- dm_raddr, output, 12, data memory line read address.
- dm_rdata, input, 256, data memory line read data (combinational from dm_raddr).
- dm_wen, output, 1, data memory write enable.
- dm_waddr, output, 12, data memory line write address.
- dm_wdata, output, 256, data memory line write data.

Behaviour:
Reset (rst=0 at a clock edge):
- Reset overrides everything.
- state=IDLE; line_valid=0; dirty=0; tag=0; buffer words=0.
- All outputs are 0, except req_ready=1 in the first cycle after reset is released.
- Reset in FLUSH/FILL/RESP aborts the operation: no dm_wen after reset, and a pending response is dropped.

Lane packing (fixed by the memory):
- Read: word i = dm_rdata[255-16i -: 16], so word 0 is the MSBs.
- Write: word i = dm_wdata[16i+15 : 16i], so word 0 is the LSBs.
- The adapter reverses lane order between fill and flush.

States and transitions:
- IDLE: req_ready = 1 iff flush_req=0.
  - Accept when req_valid & req_ready.
  - Hit = line_valid & tag == req_addr[15:4].
- Hit:
  - Load: latch word; go to RESP.
  - Store: write word into buffer, set dirty=1; go to RESP.
  - Hit latency is 1: resp_valid in the cycle after acceptance.
- Miss with dirty=1: latch the request; go to FLUSH.
- Miss with dirty=0 (or line_valid=0): latch the request; go to FILL.
- FLUSH:
  - dm_wen=1, dm_waddr=tag, dm_wdata=packed buffer, for exactly one cycle.
  - At the edge: dirty=0. Next state is FILL for a miss, or IDLE with flush_done=1 for a flush.
- FILL:
  - dm_raddr = latched line address.
  - At the edge: capture unpacked dm_rdata, tag = line address, line_valid=1.
  - Apply a latched store (dirty=1) or select a latched load word. Go to RESP.
- RESP: resp_valid=1 for one cycle, resp_rdata driven. Next state is IDLE.

Latency (acceptance to resp_valid):
- Hit: 1 cycle.
- Clean miss: 2 cycles.
- Dirty miss: 3 cycles.
- req_ready=0 in FLUSH, FILL and RESP; at most one request is outstanding.

Flush:
- Sampled only in IDLE, and takes priority over req_valid in the same cycle.
- dirty=1: FLUSH, then flush_done pulses the cycle after the write.
- dirty=0: flush_done pulses the next cycle with no dm_wen.
- line_valid is unchanged by a flush.

Outputs outside their states:
- dm_wen=0.
- dm_raddr holds its last value (no functional effect).
- dm_wdata=0.

Ordering: the memory write lands at the edge ending FLUSH, so a FILL in the following cycle already observes it.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req_valid=1 -> req_ready=0, resp_valid=0, dm_wen=0. Release -> req_ready=1.
- Clean miss load, addr 0x0123, memory line 0x012 preloaded with word3=0xBEEF -> dm_raddr=0x012 in the FILL cycle; resp_valid 2 cycles after accept with resp_rdata=0xBEEF. Reload of 0x0125 -> 1-cycle hit, no dm access.
- Store combine:
  - Stores 0x1111 @0x0120 and 0x2222 @0x012F, both hits after fill, no dm_wen.
  - Then load 0x0450 -> FLUSH with dm_waddr=0x012, dm_wdata[15:0]=0x1111, dm_wdata[255:240]=0x2222.
  - Then FILL of 0x045; resp 3 cycles after accept.
- Round trip: after the flush above, load 0x0120 -> returns 0x1111, proving the lane reversal is correct.
- Flush: flush_req and req_valid both high with the line dirty -> req_ready=0, one dm_wen cycle, flush_done next cycle. Flush again immediately -> flush_done after 1 cycle, no dm_wen.
- Reset mid-operation: assert rst=0 during FLUSH -> no further dm_wen, no resp_valid. After release, the load misses (line_valid=0).
